// File: rtl/tanh_sched_pkg.sv
// Shared types and helpers for the time-shared tanh LUT scheduler family.
package tanh_sched_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_FRAC_W = DEF_DATA_W - DEF_ADDR_W;

    typedef enum logic [1:0] {IDLE, LOOKUP, INTERP, RESP} state_t;

    // Clamp a signed value into the range of a w-bit two's complement word.
    function automatic logic signed [31:0] saturate(input logic signed [31:0] v, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester after i_ptr (mod NREQ) wins.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [ID_W-1:0] i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [ID_W-1:0] o_idx,
    output logic            o_any
);

    logic [ID_W-1:0] w_j;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_j   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_j = ID_W'((int'(i_ptr) + k) % NREQ);
            if (!o_any && i_req[w_j]) begin
                o_any      = 1'b1;
                o_idx      = w_j;
                o_gnt[w_j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tanh_lut_sched.sv
// Shares one external piecewise-linear tanh LUT among NREQ requesters,
// interpolating base/next with the low input bits and returning result + ID.
module tanh_lut_sched
    import tanh_sched_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int FRAC_W = DATA_W - ADDR_W,
    parameter int ID_W   = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [DATA_W-1:0]      resp_data,
    output logic [ID_W-1:0]        resp_id,
    output logic [ADDR_W-1:0]      lut_address,
    input  logic [DATA_W-1:0]      lut_base,
    input  logic [DATA_W-1:0]      lut_next,
    output logic                   busy
);

    localparam int DIFF_W = DATA_W + 1;
    localparam int PROD_W = DATA_W + FRAC_W + 1;
    localparam int SUM_W  = DATA_W + 2;

    state_t              r_state;
    logic [FRAC_W-1:0]   r_frac;
    logic [ID_W-1:0]     r_id;
    logic [ID_W-1:0]     r_ptr;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_resp_valid;
    logic [DATA_W-1:0]   r_resp_data;
    logic [ID_W-1:0]     r_resp_id;

    logic [NREQ-1:0]     w_gnt;
    logic [ID_W-1:0]     w_idx;
    logic                w_any;
    logic [DATA_W-1:0]   w_sel;

    logic signed [DATA_W-1:0] w_base;
    logic signed [DATA_W-1:0] w_next;
    logic signed [DIFF_W-1:0] w_diff;
    logic signed [FRAC_W:0]   w_frac;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [SUM_W-1:0]  w_sum;
    logic [DATA_W-1:0]        w_sat;

    rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NREQ; i++)
            if (w_idx == ID_W'(i))
                w_sel = req_data[i*DATA_W +: DATA_W];
    end

    // Strobe is gated by reset so nothing looks accepted while held in reset.
    assign req_ready = (rst && r_state == IDLE && w_any) ? w_gnt : '0;

    // Interpolation: diff/prod widths are chosen so no intermediate can overflow.
    assign w_base = lut_base;
    assign w_next = lut_next;
    assign w_diff = DIFF_W'(w_next) - DIFF_W'(w_base);
    assign w_frac = {1'b0, r_frac};
    assign w_prod = PROD_W'(w_diff) * PROD_W'(w_frac);
    assign w_sum  = SUM_W'(w_base) + SUM_W'(w_prod >>> FRAC_W);
    assign w_sat  = DATA_W'(saturate(32'(w_sum), DATA_W));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_frac       <= '0;
            r_id         <= '0;
            r_ptr        <= ID_W'(NREQ - 1);
            r_addr       <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_id    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_frac  <= w_sel[FRAC_W-1:0];
                        r_id    <= w_idx;
                        r_ptr   <= w_idx;
                        r_addr  <= w_sel[DATA_W-1:FRAC_W];
                        r_state <= LOOKUP;
                    end
                end
                LOOKUP: r_state <= INTERP;
                INTERP: begin
                    r_resp_data  <= w_sat;
                    r_resp_id    <= r_id;
                    r_resp_valid <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign resp_valid  = r_resp_valid;
    assign resp_data   = r_resp_data;
    assign resp_id     = r_resp_id;
    assign lut_address = r_addr;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_tanh_lut_sched.sv
// Randomized bench for tanh_lut_sched with a transaction-level reference model.
module tb_tanh_lut_sched;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int AW   = 4;
    localparam int FW   = 4;
    localparam int IW   = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_ready;
    logic [NREQ*DW-1:0] req_data;
    logic            resp_valid;
    logic            resp_ready;
    logic [DW-1:0]   resp_data;
    logic [IW-1:0]   resp_id;
    logic [AW-1:0]   lut_address;
    logic [DW-1:0]   lut_base;
    logic [DW-1:0]   lut_next;
    logic            busy;

    logic [DW-1:0] lut_b [16];
    logic [DW-1:0] lut_n [16];

    int checks   = 0;
    int failures = 0;

    // model state
    int          m_ptr;
    bit          m_inf;
    int          m_cnt;
    int          m_id;
    logic [DW-1:0] m_data;
    logic [AW-1:0] m_addr;
    logic [NREQ-1:0] last_acc;
    int          cyc = 0;
    int          acc_q[$];
    int          acc_cyc[$];

    always #5 clk = ~clk;

    assign lut_base = lut_b[lut_address];
    assign lut_next = lut_n[lut_address];

    tanh_lut_sched #(.NREQ(NREQ), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data    (req_data),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_id     (resp_id),
        .lut_address (lut_address),
        .lut_base    (lut_base),
        .lut_next    (lut_next),
        .busy        (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic int first_from(input logic [NREQ-1:0] v, input int p);
        for (int k = 1; k <= NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    // Linear interpolation with floor rounding, then clamp to 8-bit signed.
    function automatic int interp(input int b, input int n, input int f);
        int p, q, r;
        p = (n - b) * f;
        q = p / (1 << FW);
        if ((p % (1 << FW)) != 0 && p < 0) q = q - 1;
        r = b + q;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    always @(negedge clk) begin
        int g;
        logic [DW-1:0] x;
        logic [NREQ-1:0] exp_rdy;
        bit exp_rv;
        cyc++;
        if (!rst) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_resp_data", resp_data, 0);
            chk("rst_resp_id", resp_id, 0);
            chk("rst_lut_address", lut_address, 0);
            chk("rst_busy", busy, 0);
            m_ptr = NREQ - 1; m_inf = 0; m_cnt = 0; m_addr = '0; last_acc = '0;
        end else begin
            exp_rv  = m_inf && m_cnt >= 2;
            g       = first_from(req_valid, m_ptr);
            exp_rdy = (!m_inf && g >= 0) ? NREQ'(1 << g) : '0;
            chk("req_ready", req_ready, exp_rdy);
            chk("busy", busy, m_inf);
            chk("resp_valid", resp_valid, exp_rv);
            chk("lut_address", lut_address, m_addr);
            if (exp_rv) begin
                chk("resp_data", resp_data, m_data);
                chk("resp_id", resp_id, m_id);
            end
            last_acc = req_valid & req_ready;
            if (m_inf) begin
                if (exp_rv && resp_ready) m_inf = 0;
                else m_cnt++;
            end else if (g >= 0) begin
                x      = req_data[g*DW +: DW];
                m_inf  = 1; m_cnt = 0; m_id = g; m_ptr = g;
                m_addr = x[DW-1:FW];
                m_data = DW'(interp($signed(lut_b[x[DW-1:FW]]), $signed(lut_n[x[DW-1:FW]]), int'(x[FW-1:0])));
                acc_q.push_back(g);
                acc_cyc.push_back(cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_accept(input int id, input string nm);
        int k;
        k = 0;
        do begin step(); k++; end while (!last_acc[id] && k < 50);
        chk({nm, "_accept"}, last_acc[id], 1);
    endtask

    task automatic send(input int id, input logic [DW-1:0] x, input logic [DW-1:0] expd, input string nm);
        int k;
        req_data[id*DW +: DW] = x;
        req_valid[id] = 1'b1;
        wait_accept(id, nm);
        req_valid[id] = 1'b0;
        k = 0;
        while (!resp_valid && k < 10) begin step(); k++; end
        chk({nm, "_latency"}, k, 2);
        chk({nm, "_data"}, resp_data, expd);
        chk({nm, "_id"}, resp_id, id);
        step();
    endtask

    task automatic drain();
        int k;
        resp_ready = 1'b1;
        k = 0;
        while ((busy || resp_valid) && k < 30) begin step(); k++; end
        chk("drain_busy", busy, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(); step();
        rst = 1'b1;
    endtask

    initial begin
        int k, rel;
        rst = 1'b0; req_valid = '0; req_data = '0; resp_ready = 1'b1;
        for (int a = 0; a < 16; a++) begin
            lut_b[a] = DW'($signed(4'(a)) * 16);
            lut_n[a] = (a == 7) ? 8'd112 : DW'($signed(4'(a)) * 16 + 16);
        end
        repeat (3) step();
        rst = 1'b1;

        // directed points on a known table
        send(0, 8'h25, 8'd37,  "x25");
        send(0, 8'h75, 8'd112, "x75");
        send(0, 8'h80, 8'h80,  "x80");
        send(0, 8'hF8, 8'hF8,  "xF8");

        // all requesters continuously valid
        do_reset();
        acc_q.delete(); acc_cyc.delete();
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = DW'($urandom);
        req_valid = '1;
        k = 0;
        while (acc_q.size() < 5 && k < 60) begin step(); k++; end
        req_valid = '0;
        chk("rr_count", acc_q.size(), 5);
        if (acc_q.size() >= 5) begin
            for (int i = 0; i < 5; i++) chk("rr_order", acc_q[i], i % NREQ);
            for (int i = 0; i < 4; i++) chk("rr_spacing", acc_cyc[i+1] - acc_cyc[i], 4);
        end
        drain();

        // backpressure with a competing request during RESP
        resp_ready = 1'b0;
        req_data[1*DW +: DW] = 8'h3A;
        req_valid[1] = 1'b1;
        wait_accept(1, "bp");
        req_valid[1] = 1'b0;
        k = 0;
        while (!resp_valid && k < 10) begin step(); k++; end
        chk("bp_valid", resp_valid, 1);
        req_data[3*DW +: DW] = 8'hC4;
        req_valid[3] = 1'b1;
        repeat (5) step();
        chk("bp_hold_id", resp_id, 1);
        chk("bp_hold_rdy", req_ready, 0);
        acc_q.delete(); acc_cyc.delete();
        resp_ready = 1'b1;
        rel = cyc;
        k = 0;
        while (acc_q.size() == 0 && k < 10) begin step(); k++; end
        chk("bp_next_grant", acc_q.size() > 0 ? acc_q[0] : -1, 3);
        chk("bp_next_cycle", acc_cyc.size() > 0 ? acc_cyc[0] : -1, rel + 2);
        req_valid[3] = 1'b0;
        drain();

        // reset while requester 2 is in INTERP
        req_data[2*DW +: DW] = 8'h25;
        req_valid[2] = 1'b1;
        wait_accept(2, "mid");
        req_valid[2] = 1'b0;
        step();
        chk("mid_busy_pre", busy, 1);
        rst = 1'b0;
        #1;
        chk("mid_async_busy", busy, 0);
        chk("mid_async_valid", resp_valid, 0);
        chk("mid_async_data", resp_data, 0);
        chk("mid_async_id", resp_id, 0);
        chk("mid_async_addr", lut_address, 0);
        req_data[0*DW +: DW] = 8'h11;
        req_data[2*DW +: DW] = 8'h22;
        req_valid = 4'b0101;
        step(); step();
        acc_q.delete(); acc_cyc.delete();
        rst = 1'b1;
        k = 0;
        while (acc_q.size() < 2 && k < 30) begin step(); k++; end
        req_valid = '0;
        chk("mid_first", acc_q.size() > 0 ? acc_q[0] : -1, 0);
        chk("mid_second", acc_q.size() > 1 ? acc_q[1] : -1, 2);
        drain();

        // random traffic over random LUT contents
        for (int a = 0; a < 16; a++) begin
            lut_b[a] = DW'($urandom);
            lut_n[a] = DW'($urandom);
        end
        for (int n = 0; n < 3000; n++) begin
            step();
            if (!rst) rst = 1'b1;
            else if ($urandom_range(0, 499) == 0) rst = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && last_acc[i]) begin
                    if ($urandom_range(0, 1) == 1) req_data[i*DW +: DW] = DW'($urandom);
                    else req_valid[i] = 1'b0;
                end else if (req_valid[i]) begin
                    if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    req_data[i*DW +: DW] = DW'($urandom);
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
        end
        rst = 1'b1;
        req_valid = '0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
